// File: rtl/memsplit_copier_if.sv
// Split request/response memory bus between the copier (master) and a
// memory slave. A request is accepted in any cycle with bus_req_o=1 and
// bus_ack_i=1. A read returns its data later, in a cycle with bus_resp_i=1.
//
// Signals (named from the copier's point of view):
//   bus_req_o    request valid
//   bus_we_o     1 = write, 0 = read
//   bus_addr_bo  word-aligned byte address
//   bus_be_bo    byte enables (always all ones)
//   bus_wdata_bo write data
//   bus_ack_i    request accepted by the slave
//   bus_resp_i   read response valid
//   bus_rdata_bi read response data
interface memsplit_copier_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_bo;
  logic [3:0]  bus_be_bo;
  logic [31:0] bus_wdata_bo;
  logic        bus_ack_i;
  logic        bus_resp_i;
  logic [31:0] bus_rdata_bi;

  modport master (
    output bus_req_o,
    output bus_we_o,
    output bus_addr_bo,
    output bus_be_bo,
    output bus_wdata_bo,
    input  bus_ack_i,
    input  bus_resp_i,
    input  bus_rdata_bi
  );

  modport slave (
    input  bus_req_o,
    input  bus_we_o,
    input  bus_addr_bo,
    input  bus_be_bo,
    input  bus_wdata_bo,
    output bus_ack_i,
    output bus_resp_i,
    output bus_rdata_bi
  );
endinterface

// File: rtl/memsplit_copier.sv
// Word copier on a split request/response bus. A start request in IDLE
// captures a source address, a destination address and a word count. The
// block then copies one word at a time: it reads the source word, waits for
// the read response, and writes that word to the destination.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle copy request, only looked at in IDLE
//   src_addr_bi  source byte address
//   dst_addr_bi  destination byte address
//   len_bi       number of 32-bit words to copy
//   busy_o       copy in progress; low in the done cycle
//   done_o       one-cycle end-of-copy pulse; an aborted copy also pulses it
//   err_o        sticky read-response timeout; the next accepted start clears it
//   bus          master side of memsplit_copier_if
module memsplit_copier #(
  parameter int unsigned RESP_TIMEOUT = 100,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_bi,
  input  logic [31:0]          dst_addr_bi,
  input  logic [LEN_WIDTH-1:0] len_bi,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  memsplit_copier_if.master    bus
);

  localparam int unsigned      TMO_W    = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FIN
  } state_t;

  state_t               state;
  logic [31:0]          src_q;
  logic [31:0]          dst_q;
  logic [31:0]          src_next;
  logic [31:0]          dst_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic [TMO_W-1:0]     tmo_cnt;

  // Addresses advance modulo 2^32; the two low address bits are dropped
  // whenever an address is put on the bus.
  always_comb begin
    src_next = src_q + 32'd4;
    dst_next = dst_q + 32'd4;
  end

  // Every bus output is a register loaded only on state transitions. The
  // request fields therefore stay constant while the slave stalls, and no
  // path runs from ack/resp to bus_req_o within a cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state            <= IDLE;
      src_q            <= '0;
      dst_q            <= '0;
      remaining        <= '0;
      tmo_cnt          <= '0;
      busy_o           <= 1'b0;
      done_o           <= 1'b0;
      err_o            <= 1'b0;
      bus.bus_req_o    <= 1'b0;
      bus.bus_we_o     <= 1'b0;
      bus.bus_addr_bo  <= '0;
      bus.bus_be_bo    <= '0;
      bus.bus_wdata_bo <= '0;
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            src_q     <= src_addr_bi;
            dst_q     <= dst_addr_bi;
            remaining <= len_bi;
            err_o     <= 1'b0;
            if (len_bi != '0) begin
              state           <= RD_REQ;
              busy_o          <= 1'b1;
              bus.bus_req_o   <= 1'b1;
              bus.bus_we_o    <= 1'b0;
              bus.bus_addr_bo <= {src_addr_bi[31:2], 2'b00};
              bus.bus_be_bo   <= 4'hF;
            end else begin
              // Zero-length copy: report completion and skip the bus.
              state  <= FIN;
              done_o <= 1'b1;
            end
          end
        end

        RD_REQ: begin
          if (bus.bus_ack_i) begin
            bus.bus_req_o <= 1'b0;
            tmo_cnt       <= '0;
            state         <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // RD_WAIT lasts at most RESP_TIMEOUT cycles. A response in the
          // last of those cycles is still taken.
          if (bus.bus_resp_i) begin
            bus.bus_wdata_bo <= bus.bus_rdata_bi;
            bus.bus_req_o    <= 1'b1;
            bus.bus_we_o     <= 1'b1;
            bus.bus_addr_bo  <= {dst_q[31:2], 2'b00};
            state            <= WR_REQ;
          end else if (tmo_cnt == TMO_LAST) begin
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= FIN;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        WR_REQ: begin
          if (bus.bus_ack_i) begin
            bus.bus_req_o <= 1'b0;
            bus.bus_we_o  <= 1'b0;
            src_q         <= src_next;
            dst_q         <= dst_next;
            remaining     <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= FIN;
            end else begin
              bus.bus_req_o   <= 1'b1;
              bus.bus_addr_bo <= {src_next[31:2], 2'b00};
              state           <= RD_REQ;
            end
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memsplit_copier.sv
// Bench for memsplit_copier: a table of copy jobs plus a hand-written
// sequence that resets the block mid-copy. A slave model with programmable
// ack/response delays serves the bus. Each job pushes its expected read and
// write requests onto a scoreboard queue. The slave compares every cycle of
// an outstanding request against the front of that queue.
module tb_memsplit_copier;
  localparam int unsigned TMO = 100;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int unsigned len;
    int unsigned ack_dly;
    int unsigned resp_dly;
    bit          no_resp;
    int unsigned poke_cyc;   // cycle in which a stray start is driven, 0 = none
    int unsigned exp_done;   // cycle of done_o, counting the start cycle as 0
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] len = '0;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int failures = 0;

  txn_t exp_q[$];
  vec_t vecs[7];

  // Slave configuration, written by the main sequence.
  int unsigned ack_dly = 0;
  int unsigned resp_dly = 0;
  bit          no_resp = 1'b0;
  logic        spur = 1'b0;

  // Slave state.
  logic        s_ack = 1'b0;
  logic        s_resp = 1'b0;
  logic [31:0] s_rdata = '0;
  int unsigned wait_cnt = 0;
  int unsigned rcnt = 0;
  bit          rpend = 1'b0;
  logic [31:0] raddr = '0;
  bit          req_prev = 1'b0;
  bit          ack_prev = 1'b0;
  bit          we_prev = 1'b0;
  logic [31:0] addr_prev = '0;

  memsplit_copier_if bus();

  memsplit_copier #(
    .RESP_TIMEOUT(TMO),
    .LEN_WIDTH(16)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .start_i(start),
    .src_addr_bi(src_addr),
    .dst_addr_bi(dst_addr),
    .len_bi(len),
    .busy_o(busy),
    .done_o(done),
    .err_o(err),
    .bus(bus)
  );

  assign bus.bus_ack_i    = s_ack;
  assign bus.bus_resp_i   = s_resp | spur;
  assign bus.bus_rdata_bi = s_rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Slave model. It samples at the falling edge and drives ack/resp for
  // the next rising edge.
  always @(negedge clk) begin
    s_resp = 1'b0;
    if (!rst_n) begin
      s_ack    = 1'b0;
      wait_cnt = 0;
      rpend    = 1'b0;
      req_prev = 1'b0;
      ack_prev = 1'b0;
    end else begin
      // Retire the request that was accepted at the last rising edge.
      if (req_prev && ack_prev) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (!we_prev && !no_resp) begin
          rpend = 1'b1;
          rcnt  = resp_dly;
          raddr = addr_prev;
        end
      end
      if (rpend) begin
        if (rcnt == 0) begin
          s_resp  = 1'b1;
          s_rdata = mem_word(raddr);
          rpend   = 1'b0;
        end else begin
          rcnt--;
        end
      end
      if (bus.bus_req_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_req actual=req(we=%0b addr=%h) required=no_request",
                   bus.bus_we_o, bus.bus_addr_bo);
        end else begin
          chk("req_we", 32'(bus.bus_we_o), 32'(exp_q[0].we));
          chk("req_addr", bus.bus_addr_bo, exp_q[0].addr);
          chk("req_be", 32'(bus.bus_be_bo), 32'h0000_000F);
          if (exp_q[0].we) chk("req_wdata", bus.bus_wdata_bo, exp_q[0].data);
        end
        if (wait_cnt == ack_dly) begin
          s_ack    = 1'b1;
          wait_cnt = 0;
        end else begin
          s_ack = 1'b0;
          wait_cnt++;
        end
      end else begin
        s_ack    = 1'b0;
        wait_cnt = 0;
      end
      req_prev  = bus.bus_req_o;
      ack_prev  = s_ack;
      we_prev   = bus.bus_we_o;
      addr_prev = bus.bus_addr_bo;
    end
  end

  // Runs one copy job. Call it just after a falling edge; it returns just
  // after a falling edge.
  task automatic run_vec(input vec_t v);
    int unsigned cyc;
    bit          seen;
    int unsigned busy_bad;
    logic [31:0] s_al;
    logic [31:0] d_al;
    txn_t        t;
    ack_dly  = v.ack_dly;
    resp_dly = v.resp_dly;
    no_resp  = v.no_resp;
    s_al = {v.src[31:2], 2'b00};
    d_al = {v.dst[31:2], 2'b00};
    for (int unsigned i = 0; i < v.len; i++) begin
      t.we   = 1'b0;
      t.addr = s_al + 32'(4 * i);
      t.data = '0;
      exp_q.push_back(t);
      if (v.no_resp) break;
      t.we   = 1'b1;
      t.addr = d_al + 32'(4 * i);
      t.data = mem_word(s_al + 32'(4 * i));
      exp_q.push_back(t);
    end
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    len      = 16'(v.len);
    @(negedge clk);
    cyc      = 1;
    seen     = 1'b0;
    busy_bad = 0;
    while (!seen && cyc <= v.exp_done + 20) begin
      if (v.poke_cyc != 0 && cyc == v.poke_cyc) begin
        start    = 1'b1;
        src_addr = 32'hDEAD_0000;
        dst_addr = 32'hBEEF_0000;
        len      = 16'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy !== (v.len != 0)) busy_bad++;
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_cycle", cyc, v.exp_done);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("err_at_done", 32'(err), 32'(v.exp_err));
    chk("busy_during_copy", busy_bad, 32'd0);
    @(negedge clk);
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("all_txns_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned done_cnt;
    int unsigned busy_cnt;
    txn_t        t;

    //           src           dst           len ack rsp nr    poke done err
    vecs[0] = '{32'h8000_0000, 32'h8000_0100, 4, 0, 0, 1'b0, 2,   13, 1'b0};
    vecs[1] = '{32'h0000_1000, 32'h0000_2000, 2, 3, 1, 1'b0, 5,   21, 1'b0};
    vecs[2] = '{32'h0000_3000, 32'h0000_3100, 0, 0, 0, 1'b0, 0,   1,  1'b0};
    vecs[3] = '{32'hFFFF_FFFC, 32'h0000_4000, 2, 0, 0, 1'b0, 0,   7,  1'b0};
    vecs[4] = '{32'h0000_0010, 32'h0000_0500, 3, 0, 0, 1'b1, 50,  102, 1'b1};
    vecs[5] = '{32'h0000_0020, 32'h0000_0040, 1, 0, 0, 1'b0, 0,   4,  1'b0};
    vecs[6] = '{32'h0000_0103, 32'h0000_0205, 1, 1, 2, 1'b0, 0,   8,  1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(bus.bus_req_o), 32'd0);
    chk("rst_we", 32'(bus.bus_we_o), 32'd0);
    chk("rst_addr", bus.bus_addr_bo, 32'd0);
    chk("rst_be", 32'(bus.bus_be_bo), 32'd0);
    chk("rst_wdata", bus.bus_wdata_bo, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while in RD_WAIT, then a stray response after release.
    ack_dly  = 0;
    resp_dly = 0;
    no_resp  = 1'b1;
    t.we   = 1'b0;
    t.addr = 32'h0000_0600;
    t.data = '0;
    exp_q.push_back(t);
    start    = 1'b1;
    src_addr = 32'h0000_0600;
    dst_addr = 32'h0000_0700;
    len      = 16'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(bus.bus_req_o), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    chk("midrst_no_done", done_cnt, 32'd0);
    chk("midrst_stays_idle", busy_cnt, 32'd0);
    chk("midrst_txns", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // The block recovers normally after the reset.
    run_vec(vecs[5]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
